controller_sequencer: RTL and testbench

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

---
 rtl/controller_sequencer.sv | 58 +++++
 tb/tb_controller_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// controller_sequencer: one-hot T1..T6 timing ring with HALT state and control-word decode
module controller_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       halt,
    output logic [5:0] tstate
);
    localparam logic [6:0] ST_T1   = 7'b0000001;
    localparam logic [6:0] ST_HALT = 7'b1000000;
    logic [6:0] s;
    logic [6:0] s_nxt;
    logic [5:0] t;
    logic       mem;
    logic       alu;
    // state register: bit6 is HALT, bits5..0 are T6..T1
    always_ff @(posedge clk)
        s <= rst ? ST_T1 : s_nxt;
    // next state: illegal codes recover to T1, HALT and run=0 hold, HLT in T4 halts
    always_comb
        s_nxt = !$onehot(s) ? ST_T1 :
                (s[6] || !run) ? s :
                (s[3] && opcode == 4'hf) ? ST_HALT :
                {1'b0, s[4:0], s[5]};
    // control decode of the current T-state and opcode, gated to zero when stopped
    always_comb begin
        t   = ($onehot(s) && run) ? s[5:0] : 6'b0;
        mem = opcode == 4'h0 || opcode == 4'h1 || opcode == 4'h2;
        alu = opcode == 4'h1 || opcode == 4'h2;
        ep  = t[0];
        cp  = t[1];
        li  = t[2];
        lm  = t[0] || (t[3] && mem);
        ce  = t[2] || (t[4] && mem);
        ei  = t[3] && mem;
        la  = (t[4] && opcode == 4'h0) || (t[5] && alu);
        lb  = t[4] && alu;
        eu  = t[5] && alu;
        su  = t[5] && opcode == 4'h2;
        ea  = t[3] && opcode == 4'he;
        lo  = t[3] && opcode == 4'he;
    end
    assign halt   = s == ST_HALT;
    assign tstate = s[5:0];
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: vector table, corner sequences and random run against a step-count model
module tb_controller_sequencer;
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100,
                            LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010,
                            SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt;
    logic [5:0] tstate;
    logic [11:0] ctl;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] op;
        logic [5:0] t;
        logic [11:0] c;
        logic       h;
    } vec_t;
    vec_t tbl[$];

    controller_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
        .su(su), .eu(eu), .lb(lb), .lo(lo), .halt(halt), .tstate(tstate)
    );

    assign ctl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // expected control word for instruction step 1..6 (0 = halted), straight from the instruction table
    function automatic logic [11:0] exp_ctl(input int step, input logic r, input logic [3:0] op);
        logic ld, ad;
        ld = op == 4'h0;
        ad = op == 4'h1 || op == 4'h2;
        if (!r || step == 0) return 12'h0;
        case (step)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: return (ld || ad) ? (EI | LM) : (op == 4'he) ? (EA | LO) : 12'h0;
            5: return ld ? (CE | LA) : ad ? (CE | LB) : 12'h0;
            6: return (op == 4'h2) ? (LA | EU | SU) : (op == 4'h1) ? (LA | EU) : 12'h0;
            default: return 12'h0;
        endcase
    endfunction

    initial begin
        int step;
        // LDA full instruction, back to T1
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h01, EP | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h02, CP, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h04, CE | LI, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h08, EI | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h10, CE | LA, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h20, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h0, 6'h01, EP | LM, 1'b0});
        // ADD
        tbl.push_back('{1'b0, 1'b1, 4'h1, 6'h02, CP, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h1, 6'h04, CE | LI, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h1, 6'h08, EI | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h1, 6'h10, CE | LB, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h1, 6'h20, LA | EU, 1'b0});
        // SUB
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h01, EP | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h02, CP, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h04, CE | LI, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h08, EI | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h10, CE | LB, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 6'h20, LA | EU | SU, 1'b0});
        // OUT
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h01, EP | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h02, CP, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h04, CE | LI, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h08, EA | LO, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h10, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'he, 6'h20, 12'h0, 1'b0});
        // run=0 freezes and blanks, then a NOP instruction
        tbl.push_back('{1'b0, 1'b0, 4'he, 6'h01, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h5, 6'h01, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h01, EP | LM, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h02, CP, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h04, CE | LI, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h08, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h10, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h20, 12'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 6'h01, EP | LM, 1'b0});

        // reset with run=1: T1 decode is visible while rst is still high
        tick();
        #3;
        chk("reset_tstate", {26'b0, tstate}, 32'h01);
        chk("reset_halt", {31'b0, halt}, 32'h0);
        chk("reset_ctl", {20'b0, ctl}, {20'b0, EP | LM});
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            run = tbl[i].run;
            opcode = tbl[i].op;
            #3;
            chk($sformatf("vec%0d_tstate", i), {26'b0, tstate}, {26'b0, tbl[i].t});
            chk($sformatf("vec%0d_ctl", i), {20'b0, ctl}, {20'b0, tbl[i].c});
            chk($sformatf("vec%0d_halt", i), {31'b0, halt}, {31'b0, tbl[i].h});
            tick();
        end

        // opcode change inside T4 is reflected immediately
        do_reset();
        opcode = 4'h0;
        tick(); tick(); tick();
        #1;
        chk("opchg_lda_t4", {20'b0, ctl}, {20'b0, EI | LM});
        opcode = 4'he;
        #1;
        chk("opchg_out_t4", {20'b0, ctl}, {20'b0, EA | LO});
        tick();

        // HLT: halts after the T4 edge and stays halted until reset
        do_reset();
        opcode = 4'hf;
        tick(); tick(); tick();
        #3;
        chk("hlt_t4_ctl", {20'b0, ctl}, 32'h0);
        chk("hlt_t4_tstate", {26'b0, tstate}, 32'h08);
        tick();
        chk("hlt_halt", {31'b0, halt}, 32'h1);
        chk("hlt_tstate", {26'b0, tstate}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            opcode = 4'($urandom);
            #3;
            chk($sformatf("hlt_hold%0d_ctl", i), {20'b0, ctl}, 32'h0);
            chk($sformatf("hlt_hold%0d_halt", i), {31'b0, halt}, 32'h1);
            chk($sformatf("hlt_hold%0d_tstate", i), {26'b0, tstate}, 32'h0);
            tick();
        end
        rst = 1'b1;
        run = 1'b1;
        tick();
        chk("hlt_rst_tstate", {26'b0, tstate}, 32'h01);
        chk("hlt_rst_halt", {31'b0, halt}, 32'h0);
        rst = 1'b0;

        // run=0 in T2 for three clocks, then cp for exactly one cycle
        do_reset();
        opcode = 4'h0;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("stall%0d_tstate", i), {26'b0, tstate}, 32'h02);
            chk($sformatf("stall%0d_cp", i), {31'b0, cp}, 32'h0);
            tick();
        end
        run = 1'b1;
        #3;
        chk("stall_release_cp", {31'b0, cp}, 32'h1);
        tick();
        chk("stall_after_tstate", {26'b0, tstate}, 32'h04);
        chk("stall_after_cp", {31'b0, cp}, 32'h0);

        // reset in ADD T5: back to T1, lb stays low through the next fetch and T4
        do_reset();
        opcode = 4'h1;
        tick(); tick(); tick(); tick();
        chk("addrst_t5_lb", {31'b0, lb}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("addrst_tstate", {26'b0, tstate}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("addrst_lb%0d", i), {31'b0, lb}, 32'h0);
            tick();
        end

        // random run/opcode/rst against a step-count model
        do_reset();
        step = 1;
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            run = ($urandom_range(0, 3) != 0);
            opcode = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            #3;
            chk($sformatf("rnd%0d_tstate", n), {26'b0, tstate},
                (step == 0) ? 32'h0 : (32'h1 << (step - 1)));
            chk($sformatf("rnd%0d_halt", n), {31'b0, halt}, {31'b0, step == 0});
            chk($sformatf("rnd%0d_ctl", n), {20'b0, ctl}, {20'b0, exp_ctl(step, run, opcode)});
            chk($sformatf("rnd%0d_onehot", n), {31'b0, $onehot(tstate) || (tstate == 6'h0 && halt)}, 32'h1);
            chk($sformatf("rnd%0d_bus", n), {31'b0, $countones({ep, ce, ei, ea, eu}) <= 1}, 32'h1);
            if (rst) step = 1;
            else if (step != 0 && run) step = (step == 4 && opcode == 4'hf) ? 0 : (step % 6) + 1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
